// File: rtl/chip_cfg_pkg.sv
// Shared types and constants for the chip_divider configuration sequencer.
// Holds the sequencer state encoding, the counter width and the divider split encodings.
package chip_cfg_pkg;

  typedef logic [3:0] cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWITCH,
    SETTLE
  } seq_state_t;

  localparam int CFG_CNT_W = 8;
  typedef logic [CFG_CNT_W-1:0] cnt_t;

  // chip_divider split encodings.
  localparam cfg_t CFG_MONO       = 4'd0;
  localparam cfg_t CFG_SPLIT_2X   = 4'd1;
  localparam cfg_t CFG_SPLIT_4X   = 4'd2;
  localparam cfg_t CFG_SPLIT_ASYM = 4'd3;

endpackage

// File: rtl/cfg_guard_timer.sv
// Loadable down-counter shared by the DRAIN and SETTLE phases.
// The last flag is high while the count is 1, the final cycle of a timed phase.
module cfg_guard_timer
  import chip_cfg_pkg::*;
#(
  parameter cnt_t RESET_VAL = cnt_t'(1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t load_val,
  input  logic dec,
  output logic last
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RESET_VAL;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == cnt_t'(1));

endmodule

// File: rtl/chip_cfg_sequencer.sv
// Sequences configuration changes for chip_divider: gate pad OEs, drain, switch, settle, re-enable.
// Optional macro CHIP_CFG_LOCK_EN adds a sticky lock input that rejects all further requests.
module chip_cfg_sequencer
  import chip_cfg_pkg::*;
#(
  parameter cfg_t        RESET_CFG     = CFG_MONO,
  parameter logic [15:0] LEGAL_MASK    = 16'h000F,
  parameter int          GUARD_CYCLES  = 4,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_cfg,
  output logic       req_ready,
  output logic [3:0] configuration,
  output logic       oe_gate,
  output logic       busy,
  output logic       done,
`ifdef CHIP_CFG_LOCK_EN
  input  logic       lock,
  output logic       locked,
`endif
  output logic       err
);

  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard
    $error("GUARD_CYCLES must be in 1..255");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  seq_state_t state_q, state_d;
  cfg_t       cfg_q, cfg_d, pend_q, pend_d;
  logic       oe_q, oe_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       in_flight_q, in_flight_d;
  logic       tmr_load, tmr_dec, tmr_last, reject;
  cnt_t       tmr_val;

  cfg_guard_timer #(.RESET_VAL(cnt_t'(SETTLE_CYCLES))) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .last     (tmr_last)
  );

`ifdef CHIP_CFG_LOCK_EN
  logic locked_q, locked_d, lock_pend_q, lock_pend_d;

  // A lock seen mid-sequence is parked and becomes sticky once the sequencer is idle again.
  always_comb begin
    locked_d    = locked_q;
    lock_pend_d = lock_pend_q;
    if (state_q == IDLE) begin
      if (lock || lock_pend_q) locked_d = 1'b1;
      lock_pend_d = 1'b0;
    end else if (lock) begin
      lock_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q    <= 1'b0;
      lock_pend_q <= 1'b0;
    end else begin
      locked_q    <= locked_d;
      lock_pend_q <= lock_pend_d;
    end
  end

  assign reject = locked_q | lock_pend_q;
  assign locked = locked_q;
`else
  assign reject = 1'b0;
`endif

  // NOTE: every signal gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    pend_d      = pend_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    in_flight_d = in_flight_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_val     = cnt_t'(GUARD_CYCLES);
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          pend_d = req_cfg;
          if (!LEGAL_MASK[req_cfg] || reject) begin
            err_d = 1'b1;
          end else if (req_cfg == cfg_q) begin
            done_d = 1'b1;
          end else begin
            state_d     = DRAIN;
            oe_d        = 1'b0;
            busy_d      = 1'b1;
            in_flight_d = 1'b1;
            tmr_load    = 1'b1;
          end
        end
      end
      DRAIN: begin
        tmr_dec = 1'b1;
        if (tmr_last) state_d = SWITCH;
      end
      SWITCH: begin
        cfg_d    = pend_q;
        tmr_load = 1'b1;
        tmr_val  = cnt_t'(SETTLE_CYCLES);
        state_d  = SETTLE;
      end
      SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_last) begin
          // The post-reset settle has no request behind it, so it completes silently.
          state_d     = IDLE;
          oe_d        = 1'b1;
          busy_d      = 1'b0;
          done_d      = in_flight_q;
          in_flight_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SETTLE;
      cfg_q       <= RESET_CFG;
      pend_q      <= RESET_CFG;
      oe_q        <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      pend_q      <= pend_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign configuration = cfg_q;
  assign oe_gate       = oe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_chip_cfg_sequencer.sv
// Self-checking bench for chip_cfg_sequencer: directed scenarios plus random traffic.
// The reference model tracks each request by elapsed cycles since its handshake.
module tb_chip_cfg_sequencer;

  localparam int          G    = 4;
  localparam int          S    = 2;
  localparam logic [3:0]  RCFG = 4'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_cfg = 4'd0;
  logic        req_ready, oe_gate, busy, done, err;
  logic [3:0]  configuration;
`ifdef CHIP_CFG_LOCK_EN
  logic        lock = 1'b0;
  logic        locked;
`endif

  always #5 clk = ~clk;

  chip_cfg_sequencer #(
    .RESET_CFG     (RCFG),
    .LEGAL_MASK    (16'h000F),
    .GUARD_CYCLES  (G),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_cfg       (req_cfg),
    .req_ready     (req_ready),
    .configuration (configuration),
    .oe_gate       (oe_gate),
    .busy          (busy),
    .done          (done),
`ifdef CHIP_CFG_LOCK_EN
    .lock          (lock),
    .locked        (locked),
`endif
    .err           (err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;
  logic [15:0] legal   = 16'h000F;

  // Model: m_since counts cycles since the handshake of the sequence in progress (0 = idle).
  logic [3:0]  m_cfg = RCFG;
  logic [3:0]  m_pend = RCFG;
  int          m_since = 0;
  bit          m_quiet = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_locked = 1'b0;
  bit          m_lock_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [3:0] c, input logic l);
    bit idle;
    bit rej;
    idle   = (m_since == 0);
    rej    = m_locked || m_lock_pend;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      m_cfg       = RCFG;
      m_pend      = RCFG;
      m_since     = G + 2;
      m_quiet     = 1'b1;
      m_locked    = 1'b0;
      m_lock_pend = 1'b0;
    end else begin
      if (idle) begin
        if (l || m_lock_pend) m_locked = 1'b1;
        m_lock_pend = 1'b0;
      end else if (l) begin
        m_lock_pend = 1'b1;
      end
      if (!idle) begin
        m_since++;
        if (m_since == G + 2) m_cfg = m_pend;
        if (m_since == G + S + 2) begin
          m_since = 0;
          m_done  = !m_quiet;
          m_quiet = 1'b0;
        end
      end else if (v) begin
        if (!legal[c] || rej)  m_err = 1'b1;
        else if (c == m_cfg)   m_done = 1'b1;
        else begin
          m_since = 1;
          m_pend  = c;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] c, input logic l);
    @(negedge clk);
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(m_since == 0));
      check("oe_gate", 32'(oe_gate), 32'(m_since == 0));
      check("busy", 32'(busy), 32'(m_since != 0));
      check("configuration", 32'(configuration), 32'(m_cfg));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
`ifdef CHIP_CFG_LOCK_EN
      check("locked", 32'(locked), 32'(m_locked));
`endif
    end
    rst       = r;
    req_valid = v;
    req_cfg   = c;
`ifdef CHIP_CFG_LOCK_EN
    lock      = l;
`endif
    @(posedge clk);
    model_update(r, v, c, l);
    chk_en = 1'b1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    logic       r, v, l;
    logic [3:0] c;

    // Reset and post-reset settle window.
    repeat (3) step(1'b1, 1'b0, 4'd0, 1'b0);
    idle_n(4);
    // Real change 0 -> 2.
    step(1'b0, 1'b1, 4'h2, 1'b0);
    idle_n(10);
    // No-op request.
    step(1'b0, 1'b1, 4'h2, 1'b0);
    idle_n(3);
    // Illegal request.
    step(1'b0, 1'b1, 4'h9, 1'b0);
    idle_n(3);
    // Request held across an in-flight sequence.
    step(1'b0, 1'b1, 4'h1, 1'b0);
    repeat (14) step(1'b0, 1'b1, 4'h3, 1'b0);
    idle_n(2);
    // Reset during DRAIN.
    step(1'b0, 1'b1, 4'h5 & 4'h3, 1'b0);
    idle_n(2);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    idle_n(5);
`ifdef CHIP_CFG_LOCK_EN
    // Lock in IDLE, rejected request, then cleared by reset.
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'h1, 1'b0);
    idle_n(3);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    idle_n(4);
    step(1'b0, 1'b1, 4'h1, 1'b0);
    idle_n(10);
    // Lock during a sequence: in-flight request completes, the next one is rejected.
    step(1'b0, 1'b1, 4'h2, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    repeat (9) step(1'b0, 1'b1, 4'h3, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    idle_n(4);
`endif
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 79) == 0);
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
      else                           c = 4'($urandom_range(0, 3));
`ifdef CHIP_CFG_LOCK_EN
      l = ($urandom_range(0, 59) == 0);
`else
      l = 1'b0;
`endif
      step(r, v, c, l);
    end
    idle_n(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
